frame_burst_former: RTL and testbench

Generates AXI-style read/write burst commands for a whole 2D region (frame or tile) of the DMA from one descriptor: base address, beats per line, line count, line stride. Each line is split into bursts limited by `MAX_BURST_LEN` and by the 4 KiB AXI boundary. It emits absolute addresses with per-line and per-frame last flags. It sits between the DMA descriptor/register front end and the AXI address-channel driver, replacing per-line offset generation.

---
 rtl/frame_burst_former.sv | 109 ++++++++++
 tb/tb_frame_burst_former.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/frame_burst_former.sv
// frame_burst_former: splits a 2D DMA descriptor into AXI bursts bounded by MAX_BURST_LEN and BOUNDARY
module frame_burst_former #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 64,
  parameter int LEN_W         = 16,
  parameter int MAX_BURST_LEN = 255,
  parameter int BOUNDARY      = 4096
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] desc_base_i,
  input  logic [LEN_W-1:0]  desc_line_beats_i,
  input  logic [LEN_W-1:0]  desc_line_count_i,
  input  logic [ADDR_W-1:0] desc_stride_i,
  input  logic              desc_valid_i,
  output logic              desc_ready_o,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic [7:0]        cmd_len_o,
  output logic              cmd_last_line_o,
  output logic              cmd_last_frame_o,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic              busy_o,
  output logic              done_o
);
  localparam int BYTES = DATA_W / 8;
  localparam int SH = $clog2(BYTES);
  localparam logic [ADDR_W-1:0] BEAT_MASK = ADDR_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] BND_MASK = ADDR_W'(BOUNDARY - 1);
  typedef enum logic [1:0] {IDLE, CALC, VALID, DONE} state_t;
  state_t state, state_n;
  logic rdy_en;
  logic [ADDR_W-1:0] line_addr, addr, stride;
  logic [LEN_W-1:0] line_beats, left, lines_left;
  logic [8:0] beats, beats_n;
  logic [31:0] bnd, cap, lim;
  logic accept, last_line_n;
  assign accept = desc_valid_i && desc_ready_o;
  assign desc_ready_o = (state == IDLE) && rdy_en;
  assign cmd_valid_o = state == VALID;
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  // burst size is the tightest of remaining beats, AXI len limit and distance to the next boundary
  always_comb begin
    bnd = (32'(BOUNDARY) - 32'(addr & BND_MASK)) >> SH;
    cap = (32'(left) < 32'(MAX_BURST_LEN + 1)) ? 32'(left) : 32'(MAX_BURST_LEN + 1);
    lim = (bnd < cap) ? bnd : cap;
    beats_n = 9'(lim);
    last_line_n = lim == 32'(left);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = !accept ? IDLE : (desc_line_beats_i == '0 || desc_line_count_i == '0) ? DONE : CALC;
      CALC:  state_n = VALID;
      VALID: state_n = !cmd_ready_i ? VALID : cmd_last_frame_o ? DONE : CALC;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      rdy_en <= 1'b0;
      line_addr <= '0;
      addr <= '0;
      stride <= '0;
      line_beats <= '0;
      left <= '0;
      lines_left <= '0;
      beats <= '0;
      cmd_addr_o <= '0;
      cmd_len_o <= '0;
      cmd_last_line_o <= 1'b0;
      cmd_last_frame_o <= 1'b0;
    end else begin
      state <= state_n;
      rdy_en <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          line_addr <= desc_base_i & ~BEAT_MASK;
          addr <= desc_base_i & ~BEAT_MASK;
          stride <= desc_stride_i & ~BEAT_MASK;
          line_beats <= desc_line_beats_i;
          left <= desc_line_beats_i;
          lines_left <= desc_line_count_i;
        end
        CALC: begin
          beats <= beats_n;
          cmd_len_o <= 8'(beats_n - 9'd1);
          cmd_addr_o <= addr;
          cmd_last_line_o <= last_line_n;
          cmd_last_frame_o <= last_line_n && lines_left == LEN_W'(1);
        end
        VALID: if (cmd_ready_i) begin
          if (cmd_last_line_o) begin
            line_addr <= line_addr + stride;
            addr <= line_addr + stride;
            left <= line_beats;
            lines_left <= lines_left - LEN_W'(1);
          end else begin
            addr <= addr + (ADDR_W'(beats) << SH);
            left <= left - LEN_W'(beats);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_burst_former.sv
// tb_frame_burst_former: directed checks of burst splitting, strides, backpressure and reset
module tb_frame_burst_former;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [31:0] desc_base_i = '0, desc_stride_i = '0;
  logic [15:0] desc_line_beats_i = '0, desc_line_count_i = '0;
  logic desc_valid_i = 1'b0, cmd_ready_i = 1'b0;
  logic desc_ready_o, cmd_last_line_o, cmd_last_frame_o, cmd_valid_o, busy_o, done_o;
  logic [31:0] cmd_addr_o;
  logic [7:0] cmd_len_o;
  int tests = 0, fails = 0;

  frame_burst_former dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .desc_base_i(desc_base_i), .desc_line_beats_i(desc_line_beats_i),
    .desc_line_count_i(desc_line_count_i), .desc_stride_i(desc_stride_i),
    .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
    .cmd_addr_o(cmd_addr_o), .cmd_len_o(cmd_len_o),
    .cmd_last_line_o(cmd_last_line_o), .cmd_last_frame_o(cmd_last_frame_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_desc(input logic [31:0] b, input logic [15:0] lb, input logic [15:0] lc, input logic [31:0] s);
    @(negedge clk_i);
    chk("desc_ready_idle", desc_ready_o, 1);
    desc_base_i = b;
    desc_line_beats_i = lb;
    desc_line_count_i = lc;
    desc_stride_i = s;
    desc_valid_i = 1'b1;
    @(negedge clk_i);
    desc_valid_i = 1'b0;
    chk("busy_after_accept", busy_o, 1);
    chk("desc_ready_busy", desc_ready_o, 0);
  endtask

  task automatic get_cmd(input string tag, input logic [31:0] a, input logic [7:0] l, input logic ll, input logic lf, input int stall);
    int n = 0;
    while (!cmd_valid_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 1);
    for (int i = 0; i < stall; i++) begin
      chk({tag, "_stall_addr"}, cmd_addr_o, a);
      chk({tag, "_stall_len"}, cmd_len_o, l);
      chk({tag, "_stall_ready"}, desc_ready_o, 0);
      @(negedge clk_i);
      chk({tag, "_stall_valid"}, cmd_valid_o, 1);
    end
    chk({tag, "_addr"}, cmd_addr_o, a);
    chk({tag, "_len"}, cmd_len_o, l);
    chk({tag, "_last_line"}, cmd_last_line_o, ll);
    chk({tag, "_last_frame"}, cmd_last_frame_o, lf);
    cmd_ready_i = 1'b1;
    @(negedge clk_i);
    cmd_ready_i = 1'b0;
    chk({tag, "_valid_drop"}, cmd_valid_o, 0);
    chk({tag, "_done"}, done_o, lf);
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk_i);
    chk({tag, "_done_clear"}, done_o, 0);
    chk({tag, "_busy_clear"}, busy_o, 0);
    chk({tag, "_ready_back"}, desc_ready_o, 1);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk_i);
    chk("rst_desc_ready", desc_ready_o, 0);
    chk("rst_cmd_valid", cmd_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_addr", cmd_addr_o, 0);
    chk("rst_len", cmd_len_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_rst_ready", desc_ready_o, 1);

    send_desc(32'h0, 16'd256, 16'd1, 32'h0);
    get_cmd("s1", 32'h0, 8'd255, 1, 1, 0);
    expect_idle("s1");

    send_desc(32'h0, 16'd600, 16'd1, 32'h0);
    get_cmd("s2a", 32'h0, 8'd255, 0, 0, 0);
    get_cmd("s2b", 32'h800, 8'd255, 0, 0, 0);
    get_cmd("s2c", 32'h1000, 8'd87, 1, 1, 0);
    expect_idle("s2");

    send_desc(32'hF80, 16'd32, 16'd1, 32'h0);
    get_cmd("s3a", 32'hF80, 8'd15, 0, 0, 0);
    get_cmd("s3b", 32'h1000, 8'd15, 1, 1, 0);
    expect_idle("s3");

    send_desc(32'h10000, 16'd4, 16'd3, 32'h400);
    get_cmd("s4a", 32'h10000, 8'd3, 1, 0, 0);
    get_cmd("s4b", 32'h10400, 8'd3, 1, 0, 0);
    get_cmd("s4c", 32'h10800, 8'd3, 1, 1, 0);
    expect_idle("s4");

    send_desc(32'h0, 16'd600, 16'd1, 32'h0);
    get_cmd("s5a", 32'h0, 8'd255, 0, 0, 5);
    get_cmd("s5b", 32'h800, 8'd255, 0, 0, 5);
    get_cmd("s5c", 32'h1000, 8'd87, 1, 1, 5);
    expect_idle("s5");

    send_desc(32'h40, 16'd5, 16'd0, 32'h0);
    chk("zero_done", done_o, 1);
    chk("zero_no_cmd", cmd_valid_o, 0);
    expect_idle("zero");
    chk("zero_no_cmd_after", cmd_valid_o, 0);

    send_desc(32'h0, 16'd600, 16'd1, 32'h0);
    get_cmd("r1", 32'h0, 8'd255, 0, 0, 0);
    n = 0;
    while (!cmd_valid_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("r2_latency", 64'(n), 1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("mid_rst_valid", cmd_valid_o, 0);
    chk("mid_rst_ready", desc_ready_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_done", done_o, 0);
    chk("mid_rst_addr", cmd_addr_o, 0);
    chk("mid_rst_len", cmd_len_o, 0);
    chk("mid_rst_ll", cmd_last_line_o, 0);
    chk("mid_rst_lf", cmd_last_frame_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("after_rst_ready", desc_ready_o, 1);
    chk("after_rst_done", done_o, 0);
    chk("after_rst_valid", cmd_valid_o, 0);

    send_desc(32'h0, 16'd1, 16'd1, 32'h0);
    get_cmd("s6", 32'h0, 8'd0, 1, 1, 0);
    expect_idle("s6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
